seg7_word_decoder: RTL and testbench

Receives a stream of active-low 7-segment patterns, one digit per handshake, and decodes each back to its hex nibble. It assembles DIGITS nibbles into one word and presents it on a valid/ready output. The block sits downstream of anything that emits hex-display patterns, such as a captured display bus or a loop-back check of the display path, and recovers the binary value being displayed. Patterns that are not one of the 16 legal hex glyphs are flagged.

---
 rtl/seg7_word_decoder.sv | 138 +++++++++++++
 tb/tb_seg7_word_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder
// Decodes a stream of active-low 7-segment hex glyphs back to nibbles,
// packs DIGITS of them (first digit most significant) into one word and
// presents the word on a valid/ready output. Any pattern that is not one
// of the 16 hex glyphs decodes to 0 and sets a sticky per-word error flag.

module seg7_word_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  input  logic                  out_ready,
  output logic                  word_error,
  output logic [3:0]            digit_count
);

  localparam int         VW   = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [VW-1:0]   value_q;
  logic [3:0]      count_q;
  logic            err_q;

  logic            accept;
  logic            flush;
  logic [4:0]      decoded;
  logic [VW-1:0]   shifted;

  // Glyph lookup: {illegal, nibble}. Unknown patterns map to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign decoded = seg_decode(seg_in);

  // clear wins over both the input accept and the output handshake, so the
  // digit offered alongside clear is never consumed.
  assign accept = seg_valid & (state_q == COLLECT) & ~clear;
  assign flush  = clear | ((state_q == HOLD) & out_ready);

  // A single-digit word has nothing to shift; the new nibble is the word.
  generate
    if (DIGITS == 1) begin : g_single
      assign shifted = decoded[3:0];
    end else begin : g_multi
      assign shifted = {value_q[VW-5:0], decoded[3:0]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the accept that completes the word moves to HOLD.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (accept && count_q == LAST) state_d = HOLD;
        HOLD:    if (out_ready) state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    seg_ready   = 1'b0;
    value_valid = 1'b0;
    case (state_q)
      COLLECT: seg_ready   = 1'b1;
      HOLD:    value_valid = 1'b1;
      default: seg_ready   = 1'b0;
    endcase
  end

  // Word assembly: shift in on accept, zero on handshake or clear, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else if (flush) begin
      value_q <= '0;
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      value_q <= shifted;
      count_q <= count_q + 4'd1;
      err_q   <= err_q | decoded[4];
    end
  end

  assign value       = value_q;
  assign word_error  = err_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Bench for seg7_word_decoder: directed scenarios and a randomized phase on
// a 4-digit instance compared every cycle against a queue-based model, plus
// a full 128-pattern sweep on a 1-digit instance.

module tb_seg7_word_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // 4-digit instance
  logic [6:0]  seg_in = 7'h00;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic        clear = 1'b0;
  logic [15:0] value;
  logic        value_valid;
  logic        out_ready = 1'b0;
  logic        word_error;
  logic [3:0]  digit_count;

  // 1-digit instance
  logic [6:0]  seg_in1 = 7'h00;
  logic        seg_valid1 = 1'b0;
  logic        seg_ready1;
  logic        clear1 = 1'b0;
  logic [3:0]  value1;
  logic        value_valid1;
  logic        out_ready1 = 1'b0;
  logic        word_error1;
  logic [3:0]  digit_count1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_word_decoder #(.DIGITS(4)) dut (
    .clock(clock), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .clear(clear), .value(value), .value_valid(value_valid),
    .out_ready(out_ready), .word_error(word_error), .digit_count(digit_count)
  );

  seg7_word_decoder #(.DIGITS(1)) dut1 (
    .clock(clock), .reset(reset), .seg_in(seg_in1), .seg_valid(seg_valid1),
    .seg_ready(seg_ready1), .clear(clear1), .value(value1), .value_valid(value_valid1),
    .out_ready(out_ready1), .word_error(word_error1), .digit_count(digit_count1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: search the glyph table; returns -1 for an illegal pattern.
  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  // Model: the word is just the list of nibbles received so far.
  logic [3:0] mq[$];
  bit         merr;

  function automatic logic [15:0] mvalue();
    logic [15:0] v = 16'h0;
    foreach (mq[i]) v = {v[11:0], mq[i]};
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    int idx;
    if (reset) begin
      mq.delete();
      merr = 1'b0;
    end else if (clear) begin
      mq.delete();
      merr = 1'b0;
    end else if (mq.size() == 4) begin
      if (out_ready) begin
        mq.delete();
        merr = 1'b0;
      end
    end else if (seg_valid) begin
      idx = lookup(seg_in);
      mq.push_back(idx < 0 ? 4'h0 : 4'(idx));
      if (idx < 0) merr = 1'b1;
    end
  end

  // Compare the 4-digit DUT against the model every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      chk("cmp_seg_ready",   seg_ready,   (mq.size() != 4));
      chk("cmp_value_valid", value_valid, (mq.size() == 4));
      chk("cmp_value",       value,       mvalue());
      chk("cmp_digit_count", digit_count, mq.size());
      chk("cmp_word_error",  word_error,  merr);
    end
  end

  task automatic send_digit(input logic [6:0] code);
    int waited = 0;
    @(negedge clock);
    seg_in    = code;
    seg_valid = 1'b1;
    while (!seg_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!seg_ready) begin
      n_checks++;
      $display("FAIL send_timeout: seg_ready=%0b required 1", seg_ready);
    end
  endtask

  task automatic send_word(input logic [6:0] c0, input logic [6:0] c1,
                           input logic [6:0] c2, input logic [6:0] c3);
    send_digit(c0);
    send_digit(c1);
    send_digit(c2);
    send_digit(c3);
    @(negedge clock);
    seg_valid = 1'b0;
  endtask

  initial begin
    int idx;
    repeat (2) @(negedge clock);
    chk("rst_seg_ready",   seg_ready,   1'b1);
    chk("rst_value_valid", value_valid, 1'b0);
    chk("rst_value",       value,       16'h0);
    chk("rst_digit_count", digit_count, 4'd0);
    chk("rst_word_error",  word_error,  1'b0);
    reset = 1'b0;

    // Word 1234 with consumer always ready: valid for exactly one cycle.
    out_ready = 1'b1;
    send_word(7'h79, 7'h24, 7'h30, 7'h19);
    chk("w1234_valid", value_valid, 1'b1);
    chk("w1234_value", value, 16'h1234);
    chk("w1234_err",   word_error, 1'b0);
    chk("w1234_count", digit_count, 4'd4);
    @(negedge clock);
    chk("w1234_valid_drop", value_valid, 1'b0);

    // Word ABCD held for 5 cycles with stray seg_valid pulses.
    out_ready = 1'b0;
    send_word(7'h08, 7'h03, 7'h46, 7'h21);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", seg_ready, 1'b0);
      chk("hold_value", value, 16'hABCD);
      seg_valid = 1'($urandom_range(0, 1));
      seg_in    = 7'h40;
      @(negedge clock);
    end
    chk("hold_value_end", value, 16'hABCD);
    seg_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("release_ready", seg_ready, 1'b1);
    chk("release_count", digit_count, 4'd0);

    // Illegal glyph in the second position.
    send_word(7'h40, 7'h7F, 7'h0E, 7'h06);
    chk("illegal_value", value, 16'h00FE);
    chk("illegal_err",   word_error, 1'b1);
    send_word(7'h79, 7'h24, 7'h30, 7'h19);
    chk("after_illegal_err", word_error, 1'b0);

    // clear together with an offered digit.
    send_digit(7'h12);
    send_digit(7'h02);
    @(negedge clock);
    clear     = 1'b1;
    seg_valid = 1'b1;
    seg_in    = 7'h78;
    @(negedge clock);
    clear     = 1'b0;
    seg_valid = 1'b0;
    chk("clear_count", digit_count, 4'd0);
    chk("clear_value", value, 16'h0);
    send_word(7'h10, 7'h08, 7'h03, 7'h46);
    chk("after_clear_value", value, 16'h9ABC);

    // Asynchronous reset between edges after three digits.
    @(negedge clock);
    send_digit(7'h79);
    send_digit(7'h24);
    send_digit(7'h30);
    @(negedge clock);
    seg_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", seg_ready, 1'b1);
    chk("arst_valid", value_valid, 1'b0);
    chk("arst_value", value, 16'h0);
    chk("arst_count", digit_count, 4'd0);
    chk("arst_err",   word_error, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    send_word(7'h21, 7'h06, 7'h0E, 7'h40);
    chk("post_rst_value", value, 16'hDEF0);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      seg_valid = ($urandom_range(0, 3) != 0);
      seg_in    = ($urandom_range(0, 9) < 7) ? glyph[$urandom_range(0, 15)]
                                             : 7'($urandom_range(0, 127));
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 29) == 0);
    end
    @(negedge clock);
    seg_valid = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;

    // Single-digit sweep of every 7-bit pattern.
    for (int c = 0; c < 128; c++) begin
      seg_in1    = 7'(c);
      seg_valid1 = 1'b1;
      out_ready1 = 1'b0;
      @(negedge clock);
      idx = lookup(7'(c));
      chk("sweep_valid", value_valid1, 1'b1);
      chk("sweep_value", value1, (idx < 0) ? 4'h0 : 4'(idx));
      chk("sweep_err",   word_error1, (idx < 0));
      seg_valid1 = 1'b0;
      out_ready1 = 1'b1;
      @(negedge clock);
      chk("sweep_release", seg_ready1, 1'b1);
    end
    out_ready1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
